// File: rtl/ili9341_cmd_decoder_pkg.sv
// Shared ILI9341 command codes, window limits, FSM state and window types.
package pkg_ili9341;

  localparam logic [7:0] CMD_SWRESET = 8'h01;
  localparam logic [7:0] CMD_SLPIN   = 8'h10;
  localparam logic [7:0] CMD_SLPOUT  = 8'h11;
  localparam logic [7:0] CMD_DISPOFF = 8'h28;
  localparam logic [7:0] CMD_DISPON  = 8'h29;
  localparam logic [7:0] CMD_CASET   = 8'h2A;
  localparam logic [7:0] CMD_PASET   = 8'h2B;
  localparam logic [7:0] CMD_RAMWR   = 8'h2C;

  localparam logic [15:0] COL_MAX  = 16'd239;
  localparam logic [15:0] PAGE_MAX = 16'd319;

  typedef enum logic [2:0] {IDLE, PARAM, CASET, PASET, MEMWR} state_t;

  typedef struct packed {
    logic [8:0] sc;
    logic [8:0] ec;
    logic [8:0] sp;
    logic [8:0] ep;
  } win_t;

  localparam win_t WIN_DEF = '{sc: 9'd0, ec: 9'd239, sp: 9'd0, ep: 9'd319};

endpackage

// File: rtl/ili9341_spi_byte_rx.sv
// Synchronizes the 4-wire SPI pins into clk and assembles MSB-first bytes.
module ili9341_spi_byte_rx
  import pkg_ili9341::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       csx,
  input  logic       dcx,
  input  logic       scl,
  input  logic       sda,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       byte_dc
);

  logic [1:0] csx_s, dcx_s, sda_s;
  logic [2:0] scl_s;
  logic [6:0] shreg;
  logic [2:0] bit_cnt;
  logic       scl_rise;

  // scl_s[2] is the previous synchronized sample, used only for edge detect
  assign scl_rise = scl_s[1] & ~scl_s[2];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      csx_s      <= 2'b11;
      dcx_s      <= 2'b00;
      sda_s      <= 2'b00;
      scl_s      <= 3'b000;
      shreg      <= '0;
      bit_cnt    <= '0;
      byte_valid <= 1'b0;
      byte_data  <= '0;
      byte_dc    <= 1'b0;
    end else begin
      csx_s      <= {csx_s[0], csx};
      dcx_s      <= {dcx_s[0], dcx};
      sda_s      <= {sda_s[0], sda};
      scl_s      <= {scl_s[1:0], scl};
      byte_valid <= 1'b0;
      if (csx_s[1]) begin
        bit_cnt <= '0;
      end else if (scl_rise) begin
        shreg <= {shreg[5:0], sda_s[1]};
        if (bit_cnt == 3'd7) begin
          bit_cnt    <= '0;
          byte_valid <= 1'b1;
          byte_data  <= {shreg, sda_s[1]};
          byte_dc    <= dcx_s[1];
        end else begin
          bit_cnt <= bit_cnt + 3'd1;
        end
      end
    end
  end

endmodule

// File: rtl/ili9341_cmd_decoder.sv
// ILI9341 SPI command decoder: commands, parameters, window setup and pixel stream.
module ili9341_cmd_decoder
  import pkg_ili9341::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        csx,
  input  logic        dcx,
  input  logic        scl,
  input  logic        sda,
  output logic        cmd_valid,
  output logic [7:0]  cmd_code,
  output logic        param_valid,
  output logic [7:0]  param_data,
  output logic [3:0]  param_idx,
  output logic        pix_valid,
  output logic [8:0]  pix_x,
  output logic [8:0]  pix_y,
  output logic [15:0] pix_data,
  output logic        sleep_out,
  output logic        disp_on,
  output logic        win_err
);

  logic        byte_valid, byte_dc;
  logic [7:0]  byte_data;
  state_t      state, state_nx;
  win_t        win;
  logic [23:0] wbuf;
  logic [3:0]  param_cnt;
  logic        pix_ph;
  logic [7:0]  pix_hi;
  logic [8:0]  cur_x, cur_y;
  logic [15:0] w_start, w_end, w_lim;
  logic        w_ok, is_win;

  ili9341_spi_byte_rx u_rx (
    .clk        (clk),
    .rst_n      (rst_n),
    .csx        (csx),
    .dcx        (dcx),
    .scl        (scl),
    .sda        (sda),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .byte_dc    (byte_dc)
  );

  // Window check uses the three buffered bytes plus the byte arriving now
  assign is_win  = (state == CASET) || (state == PASET);
  assign w_start = wbuf[23:8];
  assign w_end   = {wbuf[7:0], byte_data};
  assign w_lim   = (state == PASET) ? PAGE_MAX : COL_MAX;
  assign w_ok    = (w_start <= w_end) && (w_end <= w_lim);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    if (byte_valid) begin
      if (!byte_dc) begin
        case (byte_data)
          CMD_CASET:   state_nx = CASET;
          CMD_PASET:   state_nx = PASET;
          CMD_RAMWR:   state_nx = MEMWR;
          CMD_SWRESET: state_nx = IDLE;
          default:     state_nx = PARAM;
        endcase
      end else if (is_win && param_cnt == 4'd3) begin
        state_nx = PARAM;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmd_valid   <= 1'b0;
      cmd_code    <= 8'h00;
      param_valid <= 1'b0;
      param_data  <= '0;
      param_idx   <= '0;
      param_cnt   <= '0;
      pix_valid   <= 1'b0;
      pix_x       <= '0;
      pix_y       <= '0;
      pix_data    <= '0;
      pix_ph      <= 1'b0;
      pix_hi      <= '0;
      cur_x       <= '0;
      cur_y       <= '0;
      sleep_out   <= 1'b0;
      disp_on     <= 1'b0;
      win_err     <= 1'b0;
      win         <= WIN_DEF;
      wbuf        <= '0;
    end else begin
      cmd_valid   <= 1'b0;
      param_valid <= 1'b0;
      pix_valid   <= 1'b0;
      win_err     <= 1'b0;
      if (byte_valid && !byte_dc) begin
        cmd_valid <= 1'b1;
        cmd_code  <= byte_data;
        param_cnt <= '0;
        param_idx <= '0;
        pix_ph    <= 1'b0;
        case (byte_data)
          CMD_SLPOUT:  sleep_out <= 1'b1;
          CMD_SLPIN:   sleep_out <= 1'b0;
          CMD_DISPON:  disp_on   <= 1'b1;
          CMD_DISPOFF: disp_on   <= 1'b0;
          CMD_RAMWR: begin
            cur_x <= win.sc;
            cur_y <= win.sp;
          end
          CMD_SWRESET: begin
            param_data <= '0;
            pix_x      <= '0;
            pix_y      <= '0;
            pix_data   <= '0;
            pix_hi     <= '0;
            cur_x      <= '0;
            cur_y      <= '0;
            sleep_out  <= 1'b0;
            disp_on    <= 1'b0;
            win        <= WIN_DEF;
            wbuf       <= '0;
          end
          default: ;
        endcase
      end else if (byte_valid && state == MEMWR) begin
        if (!pix_ph) begin
          pix_hi <= byte_data;
          pix_ph <= 1'b1;
        end else begin
          pix_ph    <= 1'b0;
          pix_valid <= 1'b1;
          pix_data  <= {pix_hi, byte_data};
          pix_x     <= cur_x;
          pix_y     <= cur_y;
          if (cur_x == win.ec) begin
            cur_x <= win.sc;
            cur_y <= (cur_y == win.ep) ? win.sp : cur_y + 9'd1;
          end else begin
            cur_x <= cur_x + 9'd1;
          end
        end
      end else if (byte_valid) begin
        param_valid <= 1'b1;
        param_data  <= byte_data;
        param_idx   <= param_cnt;
        if (param_cnt != 4'hF) param_cnt <= param_cnt + 4'd1;
        if (is_win && param_cnt < 4'd3) begin
          wbuf <= {wbuf[15:0], byte_data};
        end else if (is_win && param_cnt == 4'd3) begin
          if (!w_ok)                 win_err <= 1'b1;
          else if (state == CASET) begin
            win.sc <= w_start[8:0];
            win.ec <= w_end[8:0];
          end else begin
            win.sp <= w_start[8:0];
            win.ep <= w_end[8:0];
          end
        end
      end
    end
  end

endmodule
